mod_counter: RTL and testbench

Parametrised modulo up/down counter with synchronous load, clear, single-cycle wrap pulse and an optional one-shot mode. It generalises the fixed 4-bit mod-15 counter to any width and modulus, and adds direction, load and halt-on-terminal behaviour. It sits in the timing/sequencing library and drives event schedulers, baud/tick generators and bounded loop controllers.

---
 rtl/mod_counter_pkg.sv | 13 +
 rtl/mod_counter_prescaler.sv | 36 +++
 rtl/mod_counter.sv | 112 +++++++++++
 tb/tb_mod_counter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared types and constants for the modulo up/down counter.
// The prescaler option is selected with MOD_COUNTER_PRESCALE_EN.
package mod_counter_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/mod_counter_prescaler.sv
// Enable divider: tick pulses on every PRESCALE-th enabled cycle.
// Only instantiated when MOD_COUNTER_PRESCALE_EN is defined.
module mod_counter_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    generate
        if (PRESCALE < 2) begin : g_bad_prescale
            $error("mod_counter_prescaler: PRESCALE must be >= 2");
        end
    endgenerate

    logic [PW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter with load, clear, wrap pulse and one-shot halt.
// Define MOD_COUNTER_PRESCALE_EN to step only on every PRESCALE-th enabled cycle.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 15,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             one_shot,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             done
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    generate
        if (MODULUS < 2 || longint'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
            $error("mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
        if (PRESCALE < 2) begin : g_bad_prescale
            $error("mod_counter: PRESCALE must be >= 2");
        end
    endgenerate

    // Loads above the count range pin to the top value so count never leaves it.
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] v);
        return (v > TOP) ? TOP : v;
    endfunction

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] count_next;
    logic             wrap_next;
    logic             tick;

`ifdef MOD_COUNTER_PRESCALE_EN
    mod_counter_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clear(clear || load),
        .en   (en && (state == RUN)),
        .tick (tick)
    );
`else
    assign tick = en;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            wrap  <= wrap_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        wrap_next  = 1'b0;
        if (clear) begin
            count_next = '0;
            state_next = RUN;
        end else if (load) begin
            count_next = saturate(load_val);
            state_next = RUN;
        end else if (state == RUN && tick) begin
            case (up)
                DIR_UP: begin
                    if (count == TOP) begin
                        count_next = '0;
                        wrap_next  = 1'b1;
                    end else begin
                        count_next = count + 1'b1;
                    end
                end
                DIR_DOWN: begin
                    if (count == '0) begin
                        count_next = TOP;
                        wrap_next  = 1'b1;
                    end else begin
                        count_next = count - 1'b1;
                    end
                end
                default: begin
                    count_next = count;
                end
            endcase
            // The terminal step still executes; only subsequent steps are blocked.
            if (wrap_next && one_shot) begin
                state_next = HALT;
            end
        end
    end

    assign done = (state == HALT);

endmodule

// File: tb/tb_mod_counter.sv
// Randomised scoreboard bench for mod_counter against an arithmetic reference model.
// Works with or without MOD_COUNTER_PRESCALE_EN.
module tb_mod_counter;

    localparam int W   = 4;
    localparam int MOD = 15;
    localparam int PS  = 4;

    logic         clk;
    logic         reset;
    logic         clear;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;
    logic         one_shot;
    logic [W-1:0] count;
    logic         wrap;
    logic         done;

    mod_counter #(
        .WIDTH   (W),
        .MODULUS (MOD),
        .PRESCALE(PS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .en      (en),
        .up      (up),
        .load    (load),
        .load_val(load_val),
        .one_shot(one_shot),
        .count   (count),
        .wrap    (wrap),
        .done    (done)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    // scoreboard: {count, wrap, done}
    logic [W+1:0] exp_q[$];

    // reference model state
    int m_count = 0;
    bit m_halt  = 0;
    int m_pre   = 0;

    task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got count=%0d wrap=%0b done=%0b, expected count=%0d wrap=%0b done=%0b",
                     name, act[W+1:2], act[1], act[0], exp[W+1:2], exp[1], exp[0]);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_halt  = 0;
        m_pre   = 0;
    endtask

    task automatic model_step(input bit clr, input bit ld, input int lv, input bit e,
                              input bit u, input bit os);
        bit tick;
        bit wr;
        tick = e;
`ifdef MOD_COUNTER_PRESCALE_EN
        tick = 0;
        if (clr || ld) begin
            m_pre = 0;
        end else if (e && !m_halt) begin
            if (m_pre == PS - 1) begin
                tick  = 1;
                m_pre = 0;
            end else begin
                m_pre = m_pre + 1;
            end
        end
`endif
        wr = 0;
        if (clr) begin
            m_count = 0;
            m_halt  = 0;
        end else if (ld) begin
            m_count = (lv >= MOD) ? MOD - 1 : lv;
            m_halt  = 0;
        end else if (!m_halt && tick) begin
            if (u) begin
                wr      = (m_count + 1 == MOD);
                m_count = (m_count + 1) % MOD;
            end else begin
                wr      = (m_count == 0);
                m_count = (m_count + MOD - 1) % MOD;
            end
            if (wr && os) m_halt = 1;
        end
        exp_q.push_back({m_count[W-1:0], wr, m_halt});
    endtask

    // driver: apply one cycle of inputs at the falling edge and log the expected result
    task automatic drive_cycle(input bit clr, input bit ld, input int lv, input bit e,
                               input bit u, input bit os);
        @(negedge clk);
        clear    = clr;
        load     = ld;
        load_val = W'(lv);
        en       = e;
        up       = u;
        one_shot = os;
        model_step(clr, ld, lv, e, u, os);
    endtask

    // monitor: DUT presents a result after every rising edge
    always begin
        logic [W+1:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("step", {count, wrap, done}, e);
        end
    end

    initial begin
        int guard;
        int os_hold;
        reset    = 1'b1;
        clear    = 1'b0;
        en       = 1'b0;
        up       = 1'b1;
        load     = 1'b0;
        load_val = '0;
        one_shot = 1'b0;
        #12;
        check("reset_state", {count, wrap, done}, '0);
        #1;
        reset = 1'b0;
        model_reset();

        // free-running up count
        for (int i = 0; i < 40; i++) drive_cycle(0, 0, 0, 1, 1, 0);

        // down count, then flip direction at 3
        drive_cycle(1, 0, 0, 0, 1, 0);
        guard = 0;
        drive_cycle(0, 0, 0, 1, 0, 0);
        while (m_count != 3 && guard < 400) begin
            drive_cycle(0, 0, 0, 1, 0, 0);
            guard++;
        end
        for (int i = 0; i < 6 * PS; i++) drive_cycle(0, 0, 0, 1, 1, 0);

        // load, saturating load, clear beats load
        drive_cycle(0, 1, 9, 0, 1, 0);
        drive_cycle(0, 0, 0, 0, 1, 0);
        drive_cycle(0, 1, 15, 1, 1, 0);
        drive_cycle(0, 1, 14, 1, 0, 0);
        drive_cycle(1, 1, 9, 1, 1, 0);

        // one-shot from 12; halt persists after one_shot drops
        drive_cycle(0, 1, 12, 0, 1, 1);
        for (int i = 0; i < 3 * PS + 5 * PS; i++) drive_cycle(0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 2 * PS; i++) drive_cycle(0, 0, 0, 1, 0, 0);
        drive_cycle(0, 1, 5, 1, 1, 0);
        drive_cycle(0, 0, 0, 1, 1, 0);

        // asynchronous reset between edges at count 7
        drive_cycle(1, 0, 0, 0, 1, 0);
        guard = 0;
        drive_cycle(0, 0, 0, 1, 1, 0);
        while (m_count != 7 && guard < 400) begin
            drive_cycle(0, 0, 0, 1, 1, 0);
            guard++;
        end
        @(posedge clk);
        #2;
        check("pre_reset_count", {count, wrap, done}, {4'd7, 1'b0, 1'b0});
        reset = 1'b1;
        #1;
        check("async_reset", {count, wrap, done}, '0);
        model_reset();
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3 * PS; i++) drive_cycle(0, 0, 0, 1, 1, 0);

        // enable gaps stretch the step spacing
        drive_cycle(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 12; i++) drive_cycle(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 12; i++) drive_cycle(0, 0, 0, 1, 1, 0);

        // randomised traffic
        os_hold = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) os_hold = $urandom_range(0, 1);
            drive_cycle($urandom_range(0, 29) == 0, $urandom_range(0, 14) == 0,
                        $urandom_range(0, 15), $urandom_range(0, 3) != 0,
                        $urandom_range(0, 7) != 0 ? (i / 150) % 2 == 0 : $urandom_range(0, 1),
                        os_hold[0]);
        end

        // drain
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
